// File: rtl/conversor_int_float_if.sv
// Handshake/bus bundle between an integer source and conversor_int_float.
// master: drives start/data_in; slave: returns busy/done/data_out/status_out.
interface conversor_int_float_if;
  logic        start;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  modport master (
    output start, data_in,
    input  busy, done, data_out, status_out
  );

  modport slave (
    input  start, data_in,
    output busy, done, data_out, status_out
  );
endinterface

// File: rtl/conversor_int_float.sv
// Signed int32 -> float word {sign, exp[9:0] bias 511, mant[20:0]}, one shift/cycle.
// Ports: clock_100KHz, reset (async low), bus (slave); ROUND_NEAREST_EN = nearest-even.
module conversor_int_float (
  input  logic                  clock_100KHz,
  input  logic                  reset,
  conversor_int_float_if.slave  bus
);
  localparam int BIAS   = 511;
  localparam int EXP_W  = 10;
  localparam int MANT_W = 21;

  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + 31);

  typedef enum logic [2:0] {
    IDLE, ABS, NORM, ROUND, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       in_q, in_d;
  logic              sign_q, sign_d;
  logic [31:0]       mag_q, mag_d;
  logic [5:0]        lz_q, lz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       dout_q, dout_d;
  logic [3:0]        stat_q, stat_d;

  logic [MANT_W-1:0] mant;
  logic [MANT_W-1:0] mant_r;
  logic              carry;
  logic              inc;
  logic              inexact;
  logic [EXP_W-1:0]  exp_r;

  always_comb begin
    mant    = mag_q[30:10];
    inexact = |mag_q[9:0];
`ifdef ROUND_NEAREST_EN
    inc     = mag_q[9] & ((|mag_q[8:0]) | mag_q[10]);
`else
    inc     = 1'b0;
`endif
    {carry, mant_r} = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    // all-ones mantissa rolling over bumps the exponent
    exp_r = EXP_TOP - {4'd0, lz_q}
          + {{(EXP_W-1){1'b0}}, carry};
  end

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    lz_d    = lz_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    stat_d  = stat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          in_d    = bus.data_in;
          state_d = ABS;
        end
      end
      ABS: begin
        sign_d = in_q[31];
        // -2^31 negates to itself, which is the right unsigned magnitude
        mag_d  = in_q[31] ? (~in_q + 32'd1) : in_q;
        lz_d   = 6'd0;
        state_d = (mag_d == 32'd0) ? DONE : NORM;
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          lz_d  = lz_q + 6'd1;
        end
      end
      ROUND: begin
        dout_d  = {sign_q, exp_r, mant_r};
        stat_d  = inexact ? 4'b1000 : 4'b0001;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // zero input arrives here without a pulse; emit it now
        if (!done_q) begin
          dout_d = 32'd0;
          stat_d = 4'b0001;
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      in_q    <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      lz_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      lz_q    <= lz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      stat_q  <= stat_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.data_out   = dout_q;
  assign bus.status_out = stat_q;
endmodule

// File: tb/tb_conversor_int_float.sv
// Directed scoreboard bench for conversor_int_float.
// Checks reset, encodings, status, latency, reset mid-run and busy start.
module tb_conversor_int_float;
  logic clock_100KHz = 1'b0;
  logic reset;

  always #5 clock_100KHz = ~clock_100KHz;

  conversor_int_float_if bus ();

  conversor_int_float dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .bus          (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] din,
                     input logic [31:0] ed, input logic [3:0] es,
                     input int elat);
    exp_t e;
    int   cnt;
    bit   got;
    @(negedge clock_100KHz);
    bus.data_in = din;
    bus.start   = 1'b1;
    sb.push_back('{ed, es, elat});
    @(posedge clock_100KHz);
    #1 bus.start = 1'b0;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 60) begin
      @(posedge clock_100KHz);
      #1 cnt++;
      if (bus.done) got = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    e = sb.pop_front();
    check({tag, "_data"}, 64'(bus.data_out), 64'(e.d));
    check({tag, "_status"}, 64'(bus.status_out), 64'(e.s));
    check({tag, "_latency"}, 64'(cnt), 64'(e.lat));
    @(posedge clock_100KHz);
    #1 check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_held"}, 64'(bus.data_out), 64'(e.d));
  endtask

  logic [31:0] max_exp;
  exp_t        e;
  int          ndone;
  logic [31:0] first_d;

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_data", 64'(bus.data_out), 64'd0);
    check("rst_status", 64'(bus.status_out), 64'd0);
    @(negedge clock_100KHz);
    reset = 1'b1;

    run("one",    32'd1,          32'h3FE00000, 4'b0001, 34);
    run("three",  32'd3,          32'h40100000, 4'b0001, 33);
    run("neg1",   32'hFFFFFFFF,   32'hBFE00000, 4'b0001, 34);
    run("zero",   32'd0,          32'h00000000, 4'b0001, 2);
    run("minint", 32'h80000000,   32'hC3C00000, 4'b0001, 3);
    run("neg5",   32'hFFFFFFFB,   32'hC0280000, 4'b0001, 32);
`ifdef ROUND_NEAREST_EN
    max_exp = 32'h43C00000;
`else
    max_exp = 32'h43BFFFFF;
`endif
    run("maxint", 32'h7FFFFFFF,   max_exp,      4'b1000, 4);
    run("tie_ev", 32'h00400001,   32'h42A00000, 4'b1000, 12);
`ifdef ROUND_NEAREST_EN
    run("tie_od", 32'h00400003,   32'h42A00002, 4'b1000, 12);
`else
    run("tie_od", 32'h00400003,   32'h42A00001, 4'b1000, 12);
`endif

    // async reset in the middle of normalization
    @(negedge clock_100KHz);
    bus.data_in = 32'd1;
    bus.start   = 1'b1;
    @(negedge clock_100KHz);
    bus.start = 1'b0;
    repeat (5) @(negedge clock_100KHz);
    check("mid_busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_data", 64'(bus.data_out), 64'd0);
    @(negedge clock_100KHz);
    reset = 1'b1;
    run("post_rst", 32'd3, 32'h40100000, 4'b0001, 33);

    // start pulses and data_in changes while busy are ignored
    @(negedge clock_100KHz);
    bus.data_in = 32'd1;
    bus.start   = 1'b1;
    sb.push_back('{32'h3FE00000, 4'b0001, 34});
    ndone   = 0;
    first_d = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock_100KHz);
      if (i > 0 && i < 30) begin
        bus.start   = i[0];
        bus.data_in = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        if (ndone == 1) first_d = bus.data_out;
      end
    end
    e = sb.pop_front();
    check("busy_ndone", 64'(ndone), 64'd1);
    check("busy_data", 64'(first_d), 64'(e.d));
    check("busy_held", 64'(bus.data_out), 64'(e.d));
    check("busy_idle", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
